// File: rtl/serial_reg_bridge.sv
`timescale 1ns/1ps
// Byte-stream to register-bus bridge: one command byte (bit7 = write, [6:0] = address),
// optional data byte, read data returned on the device-to-host stream.
// Define SERIAL_REG_BRIDGE_ECHO_EN to also return each written byte to the host.
module serial_reg_bridge #(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned TIMEOUT    = 4800
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_hostToDev_valid,
    output logic       o_hostToDev_ready,
    input  logic [7:0] i_hostToDev_data,
    input  logic       i_devToHost_ready,
    output logic       o_devToHost_valid,
    output logic [7:0] o_devToHost_data,
    output logic [6:0] o_regAddr,
    output logic       o_regWrEn,
    output logic [7:0] o_regWrData,
    output logic       o_regRdEn,
    input  logic [7:0] i_regRdData
);

    localparam int unsigned ToW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT);
    localparam logic [2:0] LatLast = 3'(RD_LATENCY);

    typedef enum logic [1:0] {StIdle, StWrData, StRdWait, StResp} state_t;

    state_t         state;
    logic [ToW-1:0] toCnt;
    logic [2:0]     latCnt;
    logic           hostFire;

    assign hostFire = i_hostToDev_valid && o_hostToDev_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= StIdle;
            toCnt             <= '0;
            latCnt            <= '0;
            o_hostToDev_ready <= 1'b1;
            o_devToHost_valid <= 1'b0;
            o_devToHost_data  <= '0;
            o_regAddr         <= '0;
            o_regWrEn         <= 1'b0;
            o_regWrData       <= '0;
            o_regRdEn         <= 1'b0;
        end else begin
            o_regWrEn <= 1'b0;
            o_regRdEn <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (hostFire) begin
                        o_regAddr <= i_hostToDev_data[6:0];
                        if (i_hostToDev_data[7]) begin
                            state <= StWrData;
                            toCnt <= '0;
                        end else begin
                            state             <= StRdWait;
                            latCnt            <= '0;
                            o_regRdEn         <= 1'b1;
                            o_hostToDev_ready <= 1'b0;
                        end
                    end
                end
                StWrData: begin
                    // A data byte arriving in the timeout cycle still wins.
                    if (hostFire) begin
                        o_regWrEn   <= 1'b1;
                        o_regWrData <= i_hostToDev_data;
`ifdef SERIAL_REG_BRIDGE_ECHO_EN
                        state             <= StResp;
                        o_devToHost_data  <= i_hostToDev_data;
                        o_hostToDev_ready <= 1'b0;
`else
                        state <= StIdle;
`endif
                    end else if ((TIMEOUT != 0) && (toCnt == ToMax)) begin
                        state <= StIdle;
                    end else if (toCnt != ToMax) begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                StRdWait: begin
                    if (latCnt == LatLast) begin
                        o_devToHost_data  <= i_regRdData;
                        o_devToHost_valid <= 1'b1;
                        state             <= StResp;
                    end else begin
                        latCnt <= latCnt + 1'b1;
                    end
                end
                StResp: begin
                    // Echo responses enter with valid low so the byte lands after the strobe.
                    if (!o_devToHost_valid) begin
                        o_devToHost_valid <= 1'b1;
                    end else if (i_devToHost_ready) begin
                        o_devToHost_valid <= 1'b0;
                        o_hostToDev_ready <= 1'b1;
                        state             <= StIdle;
                    end
                end
                default: begin
                    state             <= StIdle;
                    o_hostToDev_ready <= 1'b1;
                    o_devToHost_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_reg_bridge.sv
`timescale 1ns/1ps
// Directed bench for serial_reg_bridge: two instances (RD_LATENCY 1 and 3, TIMEOUT 16).
module tb_serial_reg_bridge;

`ifdef SERIAL_REG_BRIDGE_ECHO_EN
    localparam int EchoBytes = 1;
`else
    localparam int EchoBytes = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       hv     [2];
    logic [7:0] hd     [2];
    logic       dr     [2];
    logic [7:0] rdData [2];
    logic       hr     [2];
    logic       dv     [2];
    logic [7:0] dd     [2];
    logic [6:0] addr   [2];
    logic       we     [2];
    logic       re     [2];
    logic [7:0] wd     [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Monitor state, written only by the single monitor block below.
    logic [3:0] pipe     [2] = '{4'h0, 4'h0};
    int         rdCnt    [2] = '{0, 0};
    int         wrCnt    [2] = '{0, 0};
    int         respCnt  [2] = '{0, 0};
    int         accCnt   [2] = '{0, 0};
    int         dvCnt    [2] = '{0, 0};
    int         bothErr  [2] = '{0, 0};
    int         stabErr  [2] = '{0, 0};
    int         rdCyc    [2] = '{0, 0};
    int         wrCyc    [2] = '{0, 0};
    int         riseCyc  [2] = '{0, 0};
    logic [6:0] rdAddr   [2] = '{7'h0, 7'h0};
    logic [6:0] wrAddr   [2] = '{7'h0, 7'h0};
    logic [7:0] wrData   [2] = '{8'h0, 8'h0};
    logic [7:0] respData [2] = '{8'h0, 8'h0};
    logic       dvPrev   [2] = '{1'b0, 1'b0};
    logic       hsPrev   [2] = '{1'b0, 1'b0};
    logic [7:0] ddPrev   [2] = '{8'h0, 8'h0};

    function automatic int latOf(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] regModel(input logic [6:0] a);
        case (a)
            7'h12:   return 8'hA7;
            7'h01:   return 8'h5B;
            7'h03:   return 8'hC3;
            default: return {1'b0, a} ^ 8'h5A;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gDut
        serial_reg_bridge #(
            .RD_LATENCY(g == 0 ? 1 : 3),
            .TIMEOUT   (16)
        ) u_dut (
            .i_clk            (clk),
            .i_rst_n          (rst_n),
            .i_hostToDev_valid(hv[g]),
            .o_hostToDev_ready(hr[g]),
            .i_hostToDev_data (hd[g]),
            .i_devToHost_ready(dr[g]),
            .o_devToHost_valid(dv[g]),
            .o_devToHost_data (dd[g]),
            .o_regAddr        (addr[g]),
            .o_regWrEn        (we[g]),
            .o_regWrData      (wd[g]),
            .o_regRdEn        (re[g]),
            .i_regRdData      (rdData[g])
        );
    end

    // Register model drives data only in the cycle RD_LATENCY after the strobe.
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            rdData[g] = pipe[g][2'(latOf(g) - 1)] ? regModel(addr[g]) : 8'h00;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 2; g++) begin
            pipe[g] <= rst_n ? {pipe[g][2:0], re[g]} : 4'h0;
            if (re[g]) begin
                rdCnt[g]  <= rdCnt[g] + 1;
                rdCyc[g]  <= cyc;
                rdAddr[g] <= addr[g];
            end
            if (we[g]) begin
                wrCnt[g]  <= wrCnt[g] + 1;
                wrCyc[g]  <= cyc;
                wrAddr[g] <= addr[g];
                wrData[g] <= wd[g];
            end
            if (we[g] && re[g]) bothErr[g] <= bothErr[g] + 1;
            if (dv[g]) dvCnt[g] <= dvCnt[g] + 1;
            if (dv[g] && !dvPrev[g]) riseCyc[g] <= cyc;
            if (dv[g] && dr[g]) begin
                respCnt[g]  <= respCnt[g] + 1;
                respData[g] <= dd[g];
            end
            if (hv[g] && hr[g]) accCnt[g] <= accCnt[g] + 1;
            if (dvPrev[g] && !hsPrev[g] && (!dv[g] || dd[g] != ddPrev[g]))
                stabErr[g] <= stabErr[g] + 1;
            dvPrev[g] <= dv[g];
            ddPrev[g] <= dd[g];
            hsPrev[g] <= dv[g] && dr[g];
        end
    end

    // Offers a byte from a negedge; returns the index of the accepting edge.
    task automatic sendByte(input int d, input logic [7:0] b, output int accEdge);
        bit took;
        bit done;
        done    = 1'b0;
        accEdge = -1;
        hv[d]   = 1'b1;
        hd[d]   = b;
        for (int i = 0; i < 200; i++) begin
            took = hr[d];
            @(posedge clk);
            #1;
            if (took) begin
                accEdge = cyc;
                done    = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        hv[d] = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout d%0d: byte %02h not accepted, required acceptance within 200 cycles",
                     d, b);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++; if (hr[0] !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", hr[0]); end
        tests++; if (hr[1] !== 1'b1) begin fails++; $display("FAIL reset_ready1: got %b want 1", hr[1]); end
        tests++; if (dv[0] !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", dv[0]); end
        tests++; if (dd[0] !== 8'h00) begin fails++; $display("FAIL reset_data: got %02h want 00", dd[0]); end
        tests++; if (addr[0] !== 7'h00) begin fails++; $display("FAIL reset_addr: got %02h want 00", addr[0]); end
        tests++; if (we[0] !== 1'b0 || re[0] !== 1'b0) begin
            fails++; $display("FAIL reset_strobes: got we=%b re=%b want 0 0", we[0], re[0]);
        end
        tests++; if (wd[0] !== 8'h00) begin fails++; $display("FAIL reset_wrdata: got %02h want 00", wd[0]); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        int a;
        int w0;
        int r0;
        w0 = wrCnt[0];
        r0 = respCnt[0];
        sendByte(0, 8'h85, a);
        sendByte(0, 8'h3C, a);
        repeat (6) @(negedge clk);
        tests++; if (wrCnt[0] - w0 !== 1) begin fails++; $display("FAIL write_count: got %0d want 1", wrCnt[0] - w0); end
        tests++; if (wrAddr[0] !== 7'h05) begin fails++; $display("FAIL write_addr: got %02h want 05", wrAddr[0]); end
        tests++; if (wrData[0] !== 8'h3C) begin fails++; $display("FAIL write_data: got %02h want 3c", wrData[0]); end
        // Strobe is in the cycle right after the accepting edge.
        tests++; if (wrCyc[0] !== a) begin fails++; $display("FAIL write_timing: got cycle %0d want %0d", wrCyc[0], a); end
        tests++; if (respCnt[0] - r0 !== EchoBytes) begin
            fails++; $display("FAIL write_echo_count: got %0d want %0d", respCnt[0] - r0, EchoBytes);
        end
`ifdef SERIAL_REG_BRIDGE_ECHO_EN
        tests++; if (respData[0] !== 8'h3C) begin fails++; $display("FAIL write_echo_data: got %02h want 3c", respData[0]); end
        tests++; if (riseCyc[0] !== a + 1) begin
            fails++; $display("FAIL write_echo_timing: got cycle %0d want %0d", riseCyc[0], a + 1);
        end
`endif
    endtask

    task automatic test_read(input int d, input logic [6:0] ra, input logic [7:0] exp);
        int a;
        int r0;
        int p0;
        r0 = rdCnt[d];
        p0 = respCnt[d];
        sendByte(d, {1'b0, ra}, a);
        repeat (10) @(negedge clk);
        tests++; if (rdCnt[d] - r0 !== 1) begin fails++; $display("FAIL read_count d%0d: got %0d want 1", d, rdCnt[d] - r0); end
        tests++; if (rdAddr[d] !== ra) begin fails++; $display("FAIL read_addr d%0d: got %02h want %02h", d, rdAddr[d], ra); end
        tests++; if (rdCyc[d] !== a) begin fails++; $display("FAIL read_strobe_timing d%0d: got %0d want %0d", d, rdCyc[d], a); end
        // Handshake cycle is a-1; valid appears 2+RD_LATENCY cycles later.
        tests++; if (riseCyc[d] - (a - 1) !== 2 + latOf(d)) begin
            fails++; $display("FAIL read_latency d%0d: got %0d want %0d", d, riseCyc[d] - (a - 1), 2 + latOf(d));
        end
        tests++; if (respCnt[d] - p0 !== 1) begin fails++; $display("FAIL read_resp_count d%0d: got %0d want 1", d, respCnt[d] - p0); end
        tests++; if (respData[d] !== exp) begin fails++; $display("FAIL read_data d%0d: got %02h want %02h", d, respData[d], exp); end
    endtask

    task automatic test_backpressure();
        int a;
        int a2;
        int h;
        int acc0;
        int s0;
        int hrBad;
        int dvBad;
        dr[0] = 1'b0;
        s0    = stabErr[0];
        sendByte(0, 8'h01, a);
        repeat (4) @(negedge clk);
        acc0  = accCnt[0];
        hrBad = 0;
        dvBad = 0;
        hv[0] = 1'b1;
        hd[0] = 8'hFF;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (hr[0] !== 1'b0) hrBad++;
            if (dv[0] !== 1'b1 || dd[0] !== 8'h5B) dvBad++;
        end
        tests++; if (hrBad !== 0) begin fails++; $display("FAIL bp_ready_low: got %0d ready cycles want 0", hrBad); end
        tests++; if (dvBad !== 0) begin fails++; $display("FAIL bp_valid_held: got %0d bad cycles want 0", dvBad); end
        tests++; if (accCnt[0] - acc0 !== 0) begin fails++; $display("FAIL bp_no_consume: got %0d want 0", accCnt[0] - acc0); end
        tests++; if (stabErr[0] - s0 !== 0) begin fails++; $display("FAIL bp_stability: got %0d want 0", stabErr[0] - s0); end
        h     = cyc + 1;
        dr[0] = 1'b1;
        sendByte(0, 8'hFF, a2);
        tests++; if (a2 !== h + 1) begin fails++; $display("FAIL bp_next_accept: got edge %0d want %0d", a2, h + 1); end
        tests++; if (respData[0] !== 8'h5B) begin fails++; $display("FAIL bp_resp_data: got %02h want 5b", respData[0]); end
        sendByte(0, 8'h00, a2);
        repeat (4) @(negedge clk);
        tests++; if (wrAddr[0] !== 7'h7F) begin fails++; $display("FAIL bp_ff_decoded: got %02h want 7f", wrAddr[0]); end
    endtask

    task automatic test_timeout();
        int a;
        int w0;
        int r0;
        w0 = wrCnt[0];
        r0 = rdCnt[0];
        sendByte(0, 8'h90, a);
        repeat (20) @(negedge clk);
        sendByte(0, 8'h03, a);
        repeat (8) @(negedge clk);
        tests++; if (wrCnt[0] - w0 !== 0) begin fails++; $display("FAIL timeout_no_write: got %0d want 0", wrCnt[0] - w0); end
        tests++; if (rdCnt[0] - r0 !== 1) begin fails++; $display("FAIL timeout_read: got %0d want 1", rdCnt[0] - r0); end
        tests++; if (rdAddr[0] !== 7'h03) begin fails++; $display("FAIL timeout_read_addr: got %02h want 03", rdAddr[0]); end
        tests++; if (respData[0] !== 8'hC3) begin fails++; $display("FAIL timeout_read_data: got %02h want c3", respData[0]); end
    endtask

    task automatic test_timeout_boundary();
        int a;
        int b;
        int w0;
        int r0;
        // Counter holds 16 in the cycle after edge a+16; a byte there must still write.
        w0 = wrCnt[1];
        sendByte(1, 8'h9A, a);
        repeat (16) @(negedge clk);
        sendByte(1, 8'h4E, b);
        repeat (3) @(negedge clk);
        tests++; if (b !== a + 17) begin fails++; $display("FAIL tob_accept_edge: got %0d want %0d", b, a + 17); end
        tests++; if (wrCnt[1] - w0 !== 1) begin fails++; $display("FAIL tob_write: got %0d want 1", wrCnt[1] - w0); end
        tests++; if (wrAddr[1] !== 7'h1A || wrData[1] !== 8'h4E) begin
            fails++; $display("FAIL tob_write_val: got %02h/%02h want 1a/4e", wrAddr[1], wrData[1]);
        end
        repeat (4) @(negedge clk);
        // One cycle later the write is already abandoned.
        w0 = wrCnt[1];
        r0 = rdCnt[1];
        sendByte(1, 8'h9B, a);
        repeat (17) @(negedge clk);
        sendByte(1, 8'h05, b);
        repeat (10) @(negedge clk);
        tests++; if (wrCnt[1] - w0 !== 0) begin fails++; $display("FAIL tob_late_no_write: got %0d want 0", wrCnt[1] - w0); end
        tests++; if (rdCnt[1] - r0 !== 1 || rdAddr[1] !== 7'h05) begin
            fails++; $display("FAIL tob_late_read: got %0d/%02h want 1/05", rdCnt[1] - r0, rdAddr[1]);
        end
    endtask

    task automatic test_reset_midcmd();
        int a;
        int r0;
        int p0;
        int v0;
        sendByte(1, 8'h20, a);
        @(negedge clk);
        r0    = rdCnt[1];
        p0    = respCnt[1];
        v0    = dvCnt[1];
        rst_n = 1'b0;
        #1;
        tests++; if (hr[1] !== 1'b1 || dv[1] !== 1'b0) begin
            fails++; $display("FAIL rst_async: got ready=%b valid=%b want 1 0", hr[1], dv[1]);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        tests++; if (rdCnt[1] - r0 !== 0) begin fails++; $display("FAIL rst_no_rden: got %0d want 0", rdCnt[1] - r0); end
        tests++; if (respCnt[1] - p0 !== 0 || dvCnt[1] - v0 !== 0) begin
            fails++; $display("FAIL rst_no_resp: got %0d valid cycles want 0", dvCnt[1] - v0);
        end
        tests++; if (hr[1] !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", hr[1]); end
        test_read(1, 7'h12, 8'hA7);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500us, required completion earlier");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        hv    = '{1'b0, 1'b0};
        hd    = '{8'h00, 8'h00};
        dr    = '{1'b1, 1'b1};
        repeat (2) @(negedge clk);
        test_reset();
        test_write();
        test_read(0, 7'h12, 8'hA7);
        test_read(1, 7'h12, 8'hA7);
        test_backpressure();
        test_timeout();
        test_timeout_boundary();
        test_reset_midcmd();
        tests++; if (bothErr[0] + bothErr[1] !== 0) begin
            fails++; $display("FAIL strobe_exclusive: got %0d overlaps want 0", bothErr[0] + bothErr[1]);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_reg_bridge.md
# serial_reg_bridge

Byte-stream register bridge that sits downstream of the USB full-speed serial function. It consumes the host-to-device byte stream and decodes one-byte read/write commands into an 8-bit register bus. It returns read data, and optionally write echoes, on the device-to-host byte stream. It lets host software peek and poke up to 128 design registers over the USB serial link.

## Interface
- RD_LATENCY, 1, cycles from o_regRdEn high to i_regRdData valid; legal 1..4.
- TIMEOUT, 4800, cycles allowed in WR_DATA before abandoning a write command; 0 disables the timeout.

- i_clk  in  1  single clock; all logic is rising-edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_hostToDev_valid  in  1  host byte available.
- o_hostToDev_ready  out  1  bridge accepts a host byte.
- i_hostToDev_data  in  8  host byte.
- i_devToHost_ready  in  1  serial function accepts a response byte.
- o_devToHost_valid  out  1  response byte available.
- o_devToHost_data  out  8  response byte.
- o_regAddr  out  7  register address, held from command accept until the next command.
- o_regWrEn  out  1  one-cycle write strobe.
- o_regWrData  out  8  write data, valid while o_regWrEn is high.
- o_regRdEn  out  1  one-cycle read strobe.
- i_regRdData  in  8  read data, sampled RD_LATENCY cycles after the o_regRdEn cycle.

## Operation
- Command byte format: bit 7 = 1 means write, 0 means read. Bits [6:0] are the address.
- States: IDLE, WR_DATA, RD_WAIT, RESP.
- IDLE:
  - o_hostToDev_ready = 1.
  - On handshake: latch bits [6:0] into o_regAddr.
  - Bit 7 = 1: go to WR_DATA and clear the timeout counter.
  - Bit 7 = 0: go to RD_WAIT and pulse o_regRdEn.
- WR_DATA:
  - o_hostToDev_ready = 1.
  - On handshake: register the byte into o_regWrData, pulse o_regWrEn, go to IDLE (or RESP when echo is enabled).
  - Otherwise the counter increments each cycle. When it reaches TIMEOUT (TIMEOUT ≠ 0), go to IDLE with no write strobe.
- RD_WAIT:
  - o_hostToDev_ready = 0.
  - Latency counter runs from 0 up to RD_LATENCY.
  - At RD_LATENCY, capture i_regRdData into the response register and go to RESP.
- RESP:
  - o_devToHost_valid = 1 and o_devToHost_data = response register. Both are stable until the handshake.
  - o_hostToDev_ready = 0.
  - On i_devToHost_ready, go to IDLE.
- One command is in flight at a time. A new command byte is never accepted before the previous response completes.
- The host byte stream carries no framing. Loss of sync is recovered only by the WR_DATA timeout.

## Timing
- Reset values:
  - All outputs 0, except o_hostToDev_ready = 1 (IDLE).
  - State IDLE, counters 0, o_regAddr = 0, response register = 0.
- Assertion of i_rst_n low mid-command aborts the command immediately. No strobe is emitted after reset deassertion.
- All outputs are registered.
- Read path, with the command accepted at edge T:
  - o_regRdEn is high in cycle T+1 only.
  - Data is captured at the end of cycle T+1+RD_LATENCY.
  - o_devToHost_valid rises in cycle T+2+RD_LATENCY.
- Write path, with the data byte accepted at edge T: o_regWrEn and o_regWrData are valid in cycle T+1 only.
- Back-to-back: the bridge is ready for the next command the cycle after a write strobe, or the cycle after the response handshake.
- Timeout versus handshake: a data-byte handshake arriving in the same cycle the counter reaches TIMEOUT wins, and the write proceeds.
- The timeout counter width is $clog2(TIMEOUT+1) and it saturates. There is no wrap-around.
- o_devToHost_valid never drops without a handshake. i_devToHost_ready held low stalls the bridge indefinitely in RESP.
- o_regWrEn and o_regRdEn are never high in the same cycle.

## Configuration
- SERIAL_REG_BRIDGE_ECHO_EN defined:
  - After each write, the bridge enters RESP with response = written data byte.
  - Host receives one byte per write, in the cycle after the strobe.
- SERIAL_REG_BRIDGE_ECHO_EN undefined:
  - Writes are silent and return directly to IDLE.
  - Only reads produce device-to-host bytes.

## Test plan
- Write: host sends 0x85 then 0x3C → one cycle with o_regWrEn = 1, o_regAddr = 0x05, o_regWrData = 0x3C. No response byte without ECHO_EN; one byte 0x3C with ECHO_EN.
- Read, RD_LATENCY = 1 and 3: host sends 0x12, model returns 0xA7 → o_regRdEn pulses once with o_regAddr = 0x12. o_devToHost_data = 0xA7 appears exactly 2+RD_LATENCY cycles after command accept.
- Backpressure: read of address 0x01 with i_devToHost_ready held low for 50 cycles → valid and data held stable. o_hostToDev_ready = 0 throughout; 0xFF offered by the host is not consumed until after the handshake.
- Timeout, TIMEOUT = 16: host sends 0x90 then nothing for 20 cycles, then 0x03 → no write strobe. 0x03 is decoded as a read of address 0x03.
- Timeout boundary: data byte offered exactly in the cycle the counter reaches TIMEOUT → write occurs.
- Reset: i_rst_n asserted in RD_WAIT, then released → no o_regRdEn or o_devToHost_valid activity, o_hostToDev_ready = 1. Next command behaves normally.
